// File: rtl/scroll_pkg.sv
// scroll_pkg: shared state encoding, level width and tick-period helper for scroll_ctrl.
package scroll_pkg;
    localparam int LEVEL_W = 2;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] OVER   = 2'd3;

    function automatic int period_for(input int clk_div, input int level_dec, input logic [LEVEL_W-1:0] lvl);
        return clk_div - int'(lvl) * level_dec;
    endfunction
endpackage

// File: rtl/scroll_ctrl_bcd.sv
// bcd_counter: multi-digit BCD up-counter that either wraps or saturates at all-9s.
module bcd_counter #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [4*DIGITS-1:0] value
);
    logic [4*DIGITS-1:0] nxt;
    logic                carry;

    // carry out of the top digit doubles as the all-9s flag
    always_comb begin
        nxt   = value;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                nxt[4*i +: 4] = value[4*i +: 4] == 4'd9 ? 4'd0 : value[4*i +: 4] + 4'd1;
                carry = value[4*i +: 4] == 4'd9;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr)
            value <= '0;
        else if (inc && (WRAP || !carry))
            value <= nxt;
    end
endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: hold-to-move scroll ticks, modulo y offset, BCD score, difficulty level
// and start/pause/game-over sequencing for the VGA playfield.
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int CLK_DIV         = 100000,
    parameter int LEVEL_DEC       = 20000,
    parameter int MAX_LEVEL       = 3,
    parameter int DIV_W           = 18,
    parameter int SCREEN_H        = 480,
    parameter int Y_W             = 10,
    parameter int STEP            = 2,
    parameter int TICKS_PER_POINT = 10,
    parameter int LEVEL_POINTS    = 10,
    parameter int SCORE_DIGITS    = 2,
    parameter bit SCORE_WRAP      = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      move_btn,
    input  logic                      collision,
    output logic [Y_W-1:0]            y_pos,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [LEVEL_W-1:0]        level,
    output logic                      move_followers,
    output logic                      point_pulse,
    output logic                      game_over,
    output logic [1:0]                state
);
    localparam int TICK_W = $clog2(TICKS_PER_POINT + 1);
    localparam int LP_W   = $clog2(LEVEL_POINTS + 1);

    logic [DIV_W-1:0]  prescaler;
    logic [DIV_W-1:0]  limit;
    logic [TICK_W-1:0] tick_cnt;
    logic [LP_W-1:0]   lvl_cnt;
    logic [Y_W:0]      sum;
    logic [Y_W-1:0]    y_next;
    logic [1:0]        state_n;
    logic              run, paused, go, adv, tick, point, lvl_up;

    assign run    = state == RUN;
    assign paused = state == PAUSED;
    assign go     = start && (state == IDLE || state == OVER);
    assign adv    = run && !collision && !pause && move_btn;
    // >= lets a period that shrinks at level-up fire immediately instead of stalling
    assign limit  = DIV_W'(period_for(CLK_DIV, LEVEL_DEC, level) - 1);
    assign tick   = adv && prescaler >= limit;
    assign point  = tick && tick_cnt == TICK_W'(TICKS_PER_POINT - 1);
    assign lvl_up = point && lvl_cnt == LP_W'(LEVEL_POINTS - 1);
    assign sum    = {1'b0, y_pos} + (Y_W+1)'(STEP);
    assign y_next = Y_W'(sum >= (Y_W+1)'(SCREEN_H) ? sum - (Y_W+1)'(SCREEN_H) : sum);

    always_comb begin
        state_n = go                  ? RUN
                : run && collision    ? OVER
                : run && pause        ? PAUSED
                : paused && collision ? OVER
                : paused && pause     ? RUN
                : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            game_over      <= 1'b0;
            prescaler      <= '0;
            tick_cnt       <= '0;
            lvl_cnt        <= '0;
            level          <= '0;
            y_pos          <= '0;
            move_followers <= 1'b0;
            point_pulse    <= 1'b0;
        end else begin
            state          <= state_n;
            game_over      <= state_n == OVER;
            prescaler      <= go || tick ? '0 : adv ? prescaler + 1'b1 : prescaler;
            tick_cnt       <= go || point ? '0 : tick ? tick_cnt + 1'b1 : tick_cnt;
            lvl_cnt        <= go || lvl_up ? '0 : point ? lvl_cnt + 1'b1 : lvl_cnt;
            level          <= go ? '0 : lvl_up && level != LEVEL_W'(MAX_LEVEL) ? level + 1'b1 : level;
            y_pos          <= go ? '0 : tick ? y_next : y_pos;
            move_followers <= tick;
            point_pulse    <= point;
        end
    end

    bcd_counter #(.DIGITS(SCORE_DIGITS), .WRAP(SCORE_WRAP)) u_score (
        .clk  (clk),
        .reset(reset),
        .inc  (point),
        .clr  (go),
        .value(score_bcd)
    );
endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: directed self-checking bench; a wrapping and a saturating instance share stimulus.
module tb_scroll_ctrl;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, move_btn = 1'b0, collision = 1'b0;
    logic [9:0] y_a, y_b;
    logic [7:0] score_a, score_b;
    logic [1:0] level_a, level_b, state_a, state_b;
    logic       mf_a, mf_b, pp_a, pp_b, go_a, go_b;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    scroll_ctrl #(.CLK_DIV(10), .LEVEL_DEC(2), .MAX_LEVEL(2), .SCREEN_H(8), .STEP(3),
                  .TICKS_PER_POINT(3), .LEVEL_POINTS(2), .SCORE_DIGITS(2), .SCORE_WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .move_btn(move_btn), .collision(collision),
        .y_pos(y_a), .score_bcd(score_a), .level(level_a), .move_followers(mf_a),
        .point_pulse(pp_a), .game_over(go_a), .state(state_a));

    scroll_ctrl #(.CLK_DIV(10), .LEVEL_DEC(2), .MAX_LEVEL(2), .SCREEN_H(8), .STEP(3),
                  .TICKS_PER_POINT(3), .LEVEL_POINTS(2), .SCORE_DIGITS(2), .SCORE_WRAP(1'b0)) u_sat (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .move_btn(move_btn), .collision(collision),
        .y_pos(y_b), .score_bcd(score_b), .level(level_b), .move_followers(mf_b),
        .point_pulse(pp_b), .game_over(go_b), .state(state_b));

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!mf_a && n < 100);
        check("tick_timeout", 32'(mf_a), 1);
    endtask

    initial begin
        int n, seen, pts, cycles;
        repeat (2) cyc();
        check("rst_state", state_a, 0);
        check("rst_y", y_a, 0);
        check("rst_score", score_a, 0);
        check("rst_level", level_a, 0);
        check("rst_strobes", {mf_a, pp_a, go_a}, 0);
        reset = 1'b0;
        move_btn = 1'b1; pause = 1'b1; collision = 1'b1;
        cyc();
        check("idle_ignore_state", state_a, 0);
        check("idle_ignore_y", y_a, 0);
        move_btn = 1'b0; pause = 1'b0; collision = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_run", state_a, 1);
        move_btn = 1'b1;
        // ticks 1..3 at level 0, period 10
        wait_tick(n); check("t1_gap", n, 10); check("t1_y", y_a, 3); check("t1_pp", 32'(pp_a), 0);
        wait_tick(n); check("t2_gap", n, 10); check("t2_y", y_a, 6);
        wait_tick(n); check("t3_gap", n, 10); check("t3_y", y_a, 1);
        check("t3_pp", 32'(pp_a), 1); check("t3_score", score_a, 8'h01);
        cyc();
        check("strobe_one_cycle", {mf_a, pp_a}, 0);
        repeat (4) cyc();
        move_btn = 1'b0;
        seen = 0;
        repeat (20) begin
            cyc();
            seen += int'(mf_a);
        end
        check("released_no_tick", seen, 0);
        move_btn = 1'b1;
        wait_tick(n); check("t4_gap_resume", n, 5); check("t4_y", y_a, 4);
        wait_tick(n); check("t5_gap", n, 10);
        wait_tick(n); check("t6_gap", n, 10); check("t6_level", level_a, 1); check("t6_score", score_a, 8'h02);
        wait_tick(n); check("t7_gap_lvl1", n, 8);
        repeat (5) wait_tick(n);
        check("t12_level", level_a, 2); check("t12_score", score_a, 8'h04);
        wait_tick(n); check("t13_gap_lvl2", n, 6);
        repeat (5) wait_tick(n);
        check("t18_level_sat", level_a, 2); check("t18_score", score_a, 8'h06); check("t18_y", y_a, 6);
        // pause with prescaler at 2
        repeat (2) cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("paused_state", state_a, 2);
        seen = 0;
        repeat (50) begin
            cyc();
            seen += int'(mf_a) + int'(pp_a);
        end
        check("paused_no_strobe", seen, 0);
        check("paused_y", y_a, 6);
        check("paused_score", score_a, 8'h06);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("resume_state", state_a, 1);
        wait_tick(n); check("t19_gap_held", n, 4); check("t19_y", y_a, 1);
        // collision on the cycle tick 20 would fire
        repeat (5) cyc();
        collision = 1'b1;
        cyc();
        collision = 1'b0;
        check("over_state", state_a, 3);
        check("over_game_over", 32'(go_a), 1);
        check("over_y_held", y_a, 1);
        check("over_no_tick", 32'(mf_a), 0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("over_pause_ignored", state_a, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("restart_state", state_a, 1);
        check("restart_game_over", 32'(go_a), 0);
        check("restart_y", y_a, 0);
        check("restart_score", score_a, 0);
        check("restart_level", level_a, 0);
        wait_tick(n); check("restart_gap", n, 10); check("restart_y1", y_a, 3);
        pts = 0; cycles = 0;
        while (pts < 99 && cycles < 5000) begin
            cyc();
            cycles++;
            if (pp_a) pts++;
        end
        check("reach_99_points", pts, 99);
        check("score99_wrap", score_a, 8'h99);
        check("score99_sat", score_b, 8'h99);
        check("score99_level", level_a, 2);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (!pp_a && cycles < 100);
        check("p100_pp_wrap", 32'(pp_a), 1);
        check("p100_pp_sat", 32'(pp_b), 1);
        check("p100_score_wrap", score_a, 8'h00);
        check("p100_score_sat", score_b, 8'h99);
        check("p100_level_kept", level_a, 2);
        // reset on the edge where the next tick would fire
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        check("midrun_rst_state", state_a, 0);
        check("midrun_rst_y", y_a, 0);
        check("midrun_rst_score", {score_a, score_b}, 0);
        check("midrun_rst_level", level_a, 0);
        check("midrun_rst_strobes", {mf_a, pp_a, go_a, mf_b, pp_b}, 0);
        reset = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
